// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: register-file read with writeback bypass,
// prefixed or sign-extended immediates, registered outputs with stall and flush.
module operand_fetch_stage #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 16,
    parameter int PC_REG = 15,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_ir,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [3:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_opcode,
    output logic [1:0]       out_cc,
    output logic [3:0]       out_dest,
    output logic [WIDTH-1:0] out_rd_val,
    output logic [WIDTH-1:0] out_op2_val,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_pre_used
);
    localparam int         PRE_W   = WIDTH - 4;
    localparam logic [4:0] NREGS_L = 5'(NREGS);
    localparam logic [3:0] PC_ADDR = 4'(PC_REG);

    // Handshake: a transfer happens on an edge where valid && ready; a producer
    // holds its payload stable while valid && !ready.

    logic [WIDTH-1:0] regs_q [16];
    logic [WIDTH-1:0] regs_d [16];
    logic [PRE_W-1:0] pre_q, pre_d, pre_src;
    logic             pre_valid_q, pre_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       opcode_q, opcode_d;
    logic [1:0]       cc_q, cc_d;
    logic [3:0]       dest_q, dest_d;
    logic [WIDTH-1:0] rd_q, rd_d, op2_q, op2_d, pc_q, pc_d;
    logic             pre_used_q, pre_used_d;
    logic             accept, is_pre, wb_ok;

    function automatic logic [WIDTH-1:0] read_reg(input logic [3:0] a);
        if (a == PC_ADDR)
            return in_pc;
        if ({1'b0, a} >= NREGS_L)
            return '0;
        if (BYPASS != 0 && wb_en && wb_addr == a)
            return wb_data;
        return regs_q[a];
    endfunction

    assign wb_ok = wb_en && ({1'b0, wb_addr} < NREGS_L) && (wb_addr != PC_ADDR);

    always_comb begin
        regs_d = regs_q;
        if (wb_ok)
            regs_d[wb_addr] = wb_data;
    end

    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        is_pre      = (in_ir[15:14] == 2'b11);
        pre_src     = pre_valid_q ? pre_q : '0;
        pre_d       = pre_q;
        pre_valid_d = pre_valid_q;
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        cc_d        = cc_q;
        dest_d      = dest_q;
        rd_d        = rd_q;
        op2_d       = op2_q;
        pc_d        = pc_q;
        pre_used_d  = pre_used_q;
        // Flush wins over a simultaneous accept, which is silently dropped.
        if (flush) begin
            out_valid_d = 1'b0;
            pre_valid_d = 1'b0;
        end else if (accept && is_pre) begin
            pre_d       = PRE_W'({pre_src, in_ir[11:0]});
            pre_valid_d = 1'b1;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            opcode_d    = in_ir[15:11];
            cc_d        = in_ir[10:9];
            dest_d      = in_ir[7:4];
            pc_d        = in_pc;
            rd_d        = read_reg(in_ir[7:4]);
            pre_used_d  = 1'b0;
            if (!in_ir[8]) begin
                op2_d = read_reg(in_ir[3:0]);
            end else if (pre_valid_q) begin
                op2_d       = {pre_q, in_ir[3:0]};
                pre_used_d  = 1'b1;
                pre_valid_d = 1'b0;
            end else begin
                op2_d = {{(WIDTH-4){in_ir[3]}}, in_ir[3:0]};
            end
        end else if (in_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++)
                regs_q[i] <= '0;
            pre_q       <= '0;
            pre_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            cc_q        <= '0;
            dest_q      <= '0;
            rd_q        <= '0;
            op2_q       <= '0;
            pc_q        <= '0;
            pre_used_q  <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            pre_q       <= pre_d;
            pre_valid_q <= pre_valid_d;
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            cc_q        <= cc_d;
            dest_q      <= dest_d;
            rd_q        <= rd_d;
            op2_q       <= op2_d;
            pc_q        <= pc_d;
            pre_used_q  <= pre_used_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_opcode   = opcode_q;
    assign out_cc       = cc_q;
    assign out_dest     = dest_q;
    assign out_rd_val   = rd_q;
    assign out_op2_val  = op2_q;
    assign out_pc       = pc_q;
    assign out_pre_used = pre_used_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: a 16-bit bypassing instance and a 32-bit
// non-bypassing instance with 12 registers share one stimulus stream.
module tb_operand_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, flush, wb_en, out_ready;
    logic [15:0] in_ir;
    logic [31:0] in_pc, wb_data;
    logic [3:0]  wb_addr;

    logic        o16_ready, o16_valid, o16_pu;
    logic [4:0]  o16_opc;
    logic [1:0]  o16_cc;
    logic [3:0]  o16_dest;
    logic [15:0] o16_rd, o16_op2, o16_pc;
    logic        o32_ready, o32_valid, o32_pu;
    logic [4:0]  o32_opc;
    logic [1:0]  o32_cc;
    logic [3:0]  o32_dest;
    logic [31:0] o32_rd, o32_op2, o32_pc;

    int n_vec = 0;
    int n_err = 0;

    // reference model state, index 0 = 16-bit instance, 1 = 32-bit instance
    logic [31:0] m_regs [2][16];
    longint      m_pre [2];
    bit          m_pv [2];
    bit          m_valid [2];
    logic [4:0]  m_opc [2];
    logic [1:0]  m_cc [2];
    logic [3:0]  m_dest [2];
    logic [31:0] m_rd [2];
    logic [31:0] m_op2 [2];
    logic [31:0] m_pc [2];
    bit          m_pu [2];

    always #5 clk = ~clk;

    operand_fetch_stage #(.WIDTH(16), .NREGS(16), .PC_REG(15), .BYPASS(1)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o16_ready),
        .in_ir(in_ir), .in_pc(in_pc[15:0]), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data[15:0]), .out_valid(o16_valid),
        .out_ready(out_ready), .out_opcode(o16_opc), .out_cc(o16_cc),
        .out_dest(o16_dest), .out_rd_val(o16_rd), .out_op2_val(o16_op2),
        .out_pc(o16_pc), .out_pre_used(o16_pu));

    operand_fetch_stage #(.WIDTH(32), .NREGS(12), .PC_REG(15), .BYPASS(0)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o32_ready),
        .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(o32_valid),
        .out_ready(out_ready), .out_opcode(o32_opc), .out_cc(o32_cc),
        .out_dest(o32_dest), .out_rd_val(o32_rd), .out_op2_val(o32_op2),
        .out_pc(o32_pc), .out_pre_used(o32_pu));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [3:0] a);
        logic [31:0] mask = (k == 0) ? 32'h0000FFFF : 32'hFFFFFFFF;
        if (a == 4'd15) return in_pc & mask;
        if (int'(a) >= ((k == 0) ? 16 : 12)) return 32'd0;
        if (k == 0 && wb_en && wb_addr == a) return wb_data & mask;
        return m_regs[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m_regs[k][i] = '0;
            m_pre[k] = 0; m_pv[k] = 0; m_valid[k] = 0; m_pu[k] = 0;
            m_opc[k] = '0; m_cc[k] = '0; m_dest[k] = '0;
            m_rd[k] = '0; m_op2[k] = '0; m_pc[k] = '0;
        end
    endtask

    task automatic model_edge();
        longint mask, base;
        int     w, nr;
        bit     acc, is_pre;
        for (int k = 0; k < 2; k++) begin
            w      = (k == 0) ? 16 : 32;
            nr     = (k == 0) ? 16 : 12;
            mask   = (longint'(1) << w) - 1;
            acc    = in_valid && (!m_valid[k] || out_ready);
            is_pre = (in_ir[15:14] == 2'b11);
            if (flush) begin
                m_valid[k] = 0;
                m_pv[k]    = 0;
            end else if (acc && is_pre) begin
                base       = m_pv[k] ? m_pre[k] : 0;
                m_pre[k]   = (base * 4096 + longint'(in_ir[11:0])) % (longint'(1) << (w - 4));
                m_pv[k]    = 1;
                m_valid[k] = 0;
            end else if (acc) begin
                m_valid[k] = 1;
                m_opc[k]   = in_ir[15:11];
                m_cc[k]    = in_ir[10:9];
                m_dest[k]  = in_ir[7:4];
                m_pc[k]    = 32'(longint'(in_pc) & mask);
                m_rd[k]    = model_read(k, in_ir[7:4]);
                m_pu[k]    = 0;
                if (!in_ir[8]) begin
                    m_op2[k] = model_read(k, in_ir[3:0]);
                end else if (m_pv[k]) begin
                    m_op2[k] = 32'((m_pre[k] * 16 + longint'(in_ir[3:0])) & mask);
                    m_pu[k]  = 1;
                    m_pv[k]  = 0;
                end else if (in_ir[3]) begin
                    m_op2[k] = 32'((longint'(in_ir[3:0]) - 16) & mask);
                end else begin
                    m_op2[k] = 32'(in_ir[3:0]);
                end
            end else if (!m_valid[k] || out_ready) begin
                m_valid[k] = 0;
            end
            if (wb_en && int'(wb_addr) < nr && wb_addr != 4'd15)
                m_regs[k][wb_addr] = 32'(longint'(wb_data) & mask);
        end
    endtask

    task automatic cmp_dut(input int k, input logic ov, input logic [4:0] opc,
                           input logic [1:0] cc, input logic [3:0] dest,
                           input logic [31:0] rd, input logic [31:0] op2,
                           input logic [31:0] pc, input logic pu);
        string p = (k == 0) ? "w16" : "w32";
        check_eq({p, ".out_valid"}, 32'(ov), 32'(m_valid[k]));
        if (m_valid[k]) begin
            check_eq({p, ".opcode"}, 32'(opc), 32'(m_opc[k]));
            check_eq({p, ".cc"}, 32'(cc), 32'(m_cc[k]));
            check_eq({p, ".dest"}, 32'(dest), 32'(m_dest[k]));
            check_eq({p, ".rd_val"}, rd, m_rd[k]);
            check_eq({p, ".op2_val"}, op2, m_op2[k]);
            check_eq({p, ".pc"}, pc, m_pc[k]);
            check_eq({p, ".pre_used"}, 32'(pu), 32'(m_pu[k]));
        end
    endtask

    // Inputs are set just after a rising edge; step checks in_ready, advances one edge, checks outputs.
    task automatic step();
        #1;
        check_eq("w16.in_ready", 32'(o16_ready), 32'(!m_valid[0] || out_ready));
        check_eq("w32.in_ready", 32'(o32_ready), 32'(!m_valid[1] || out_ready));
        model_edge();
        @(posedge clk);
        #1;
        cmp_dut(0, o16_valid, o16_opc, o16_cc, o16_dest, {16'd0, o16_rd},
                {16'd0, o16_op2}, {16'd0, o16_pc}, o16_pu);
        cmp_dut(1, o32_valid, o32_opc, o32_cc, o32_dest, o32_rd, o32_op2, o32_pc, o32_pu);
    endtask

    task automatic set_idle();
        in_valid = 0; in_ir = '0; flush = 0; wb_en = 0; wb_addr = '0;
        wb_data = '0; out_ready = 1; in_pc = 32'h100;
    endtask

    task automatic issue(input logic [15:0] ir);
        in_valid = 1;
        in_ir    = ir;
        step();
        in_valid = 0;
    endtask

    function automatic logic [15:0] mk(input logic imm, input logic [3:0] dest, input logic [3:0] op2);
        return {5'b00001, 2'b01, imm, dest, op2};
    endfunction

    initial begin
        reset = 0;
        set_idle();
        model_reset();
        #12;
        check_eq("rst.w16.valid", 32'(o16_valid), 32'd0);
        check_eq("rst.w32.valid", 32'(o32_valid), 32'd0);
        check_eq("rst.w16.in_ready", 32'(o16_ready), 32'd1);
        check_eq("rst.w32.rd", o32_rd, 32'd0);
        check_eq("rst.w32.op2", o32_op2, 32'd0);
        check_eq("rst.w16.pc", {16'd0, o16_pc}, 32'd0);
        reset = 1;
        @(posedge clk);
        #1;

        // register read of a preloaded value
        wb_en = 1; wb_addr = 4'd3; wb_data = 32'h1234;
        step();
        wb_en = 0;
        issue(mk(1'b0, 4'd3, 4'd3));
        check_eq("tp.rd_r3", {16'd0, o16_rd}, 32'h1234);
        check_eq("tp.op2_r3", {16'd0, o16_op2}, 32'h1234);

        // sign-extended immediate, then prefix use and clear
        issue(mk(1'b1, 4'd1, 4'hA));
        check_eq("tp.sext16", {16'd0, o16_op2}, 32'hFFFA);
        check_eq("tp.sext32", o32_op2, 32'hFFFFFFFA);
        issue(16'hCABC);
        check_eq("tp.pre_bubble", 32'(o16_valid), 32'd0);
        issue(mk(1'b1, 4'd1, 4'h5));
        check_eq("tp.pre16", {16'd0, o16_op2}, 32'hABC5);
        check_eq("tp.pre_used", 32'(o16_pu), 32'd1);
        issue(mk(1'b1, 4'd1, 4'h1));
        check_eq("tp.pre_cleared", {16'd0, o16_op2}, 32'h0001);

        // chained prefixes
        issue(16'hC012);
        issue(16'hC345);
        issue(mk(1'b1, 4'd2, 4'h6));
        check_eq("tp.chain32", o32_op2, 32'h00123456);
        check_eq("tp.chain16", {16'd0, o16_op2}, 32'h3456);

        // bypass vs. no bypass, PC register read
        wb_en = 1; wb_addr = 4'd5; wb_data = 32'h1111;
        step();
        wb_data = 32'h00FF; in_pc = 32'h0042;
        issue(mk(1'b0, 4'd5, 4'd15));
        wb_en = 0;
        check_eq("tp.bypass16", {16'd0, o16_rd}, 32'h00FF);
        check_eq("tp.nobypass32", o32_rd, 32'h1111);
        check_eq("tp.pc_read", o32_op2, 32'h0042);

        // stall for three cycles with input pending
        issue(mk(1'b0, 4'd3, 4'd1));
        out_ready = 0; in_valid = 1; in_ir = {5'b00110, 2'b10, 1'b0, 4'd7, 4'd2};
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("tp.stall_ready", 32'(o16_ready), 32'd0);
            check_eq("tp.stall_hold", 32'(o16_opc), 32'h01);
        end
        out_ready = 1;
        step();
        in_valid = 0;
        check_eq("tp.release", 32'(o16_opc), 32'h06);
        step();

        // flush kills the pending prefix and a simultaneous input
        issue(16'hC777);
        flush = 1;
        issue(mk(1'b1, 4'd1, 4'h3));
        flush = 0;
        check_eq("tp.flush_drop", 32'(o16_valid), 32'd0);
        issue(mk(1'b1, 4'd1, 4'h2));
        check_eq("tp.flush_op2", {16'd0, o16_op2}, 32'h0002);
        check_eq("tp.flush_pu", 32'(o16_pu), 32'd0);

        // asynchronous reset in the middle of a stall
        issue(mk(1'b0, 4'd2, 4'd2));
        out_ready = 0;
        step();
        #2 reset = 0;
        #1;
        check_eq("tp.async_rst16", 32'(o16_valid), 32'd0);
        check_eq("tp.async_rst32", 32'(o32_valid), 32'd0);
        model_reset();
        set_idle();
        #2 reset = 1;
        @(posedge clk);
        #1;

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_ir     = 16'($urandom);
            if ($urandom_range(0, 9) < 3) in_ir[15:14] = 2'b11;
            else if (in_ir[15:14] == 2'b11) in_ir[15] = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 4);
            wb_en     = $urandom_range(0, 1) != 0;
            wb_addr   = 4'($urandom_range(0, 15));
            wb_data   = $urandom;
            in_pc     = $urandom;
            step();
        end
        set_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
